// File: rtl/led_display_pkg.sv
// led_display_pkg: shared display-mode and controller-state types.
package led_display_pkg;
  typedef enum logic [1:0] {
    MODE_BIN   = 2'b00,
    MODE_GRAY  = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BLANK = 2'b11
  } mode_e;
  typedef enum logic {SHOW, LAMP_TEST} state_e;
endpackage

// File: rtl/led_bin_display_ctrl_if.sv
// led_bin_display_ctrl_if: value/mode/test requests in, LED drive and busy out.
interface led_bin_display_ctrl_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] bin_i;
  logic             load_i;
  logic [1:0]       mode_i;
  logic             test_i;
  logic [WIDTH-1:0] led_o;
  logic             busy_o;
  modport master (output bin_i, load_i, mode_i, test_i, input led_o, busy_o);
  modport slave (input bin_i, load_i, mode_i, test_i, output led_o, busy_o);
endinterface

// File: rtl/gray_to_bin.sv
// gray_to_bin: combinational Gray-code to binary decode.
module gray_to_bin #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  // Each binary bit is the parity of the Gray bits at and above it.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    assign bin[g] = ^gray[WIDTH-1:g];
  end
endmodule

// File: rtl/led_bin_display_ctrl.sv
// led_bin_display_ctrl: registered LED display of a held value with
// binary/Gray/blink/blank modes and a one-hot walking lamp test.
module led_bin_display_ctrl
  import led_display_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 25_000_000
) (
  input logic clk,
  input logic rst,
  led_bin_display_ctrl_if.slave bus
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int WW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [WW-1:0] WALK_MAX = WW'(WIDTH - 1);
  state_e state_q, state_d;
  mode_e mode;
  logic [WIDTH-1:0] hold_q, gray_bin, map_d, led_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] walk_q, walk_d;
  logic phase_q, tick;
  assign mode = mode_e'(bus.mode_i);
  gray_to_bin #(.WIDTH(WIDTH)) u_gray (.gray(hold_q), .bin(gray_bin));
  always_comb begin
    tick = cnt_q == CNT_MAX;
    state_d = state_q;
    walk_d = walk_q;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (state_q == SHOW && bus.test_i) begin
      state_d = LAMP_TEST;
      cnt_d = '0;
      walk_d = '0;
    end else if (state_q == LAMP_TEST && tick) begin
      state_d = walk_q == WALK_MAX ? SHOW : LAMP_TEST;
      walk_d = walk_q + 1'b1;
    end
    map_d = mode == MODE_BIN ? hold_q :
            mode == MODE_GRAY ? gray_bin :
            (mode == MODE_BLINK && !phase_q) ? hold_q : '0;
    // Output follows the next state so each walk step and busy span whole ticks.
    led_d = state_d == LAMP_TEST ? WIDTH'(1) << walk_d : map_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHOW;
      hold_q <= '0;
      cnt_q <= '0;
      walk_q <= '0;
      phase_q <= 1'b0;
      bus.led_o <= '0;
      bus.busy_o <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= bus.load_i ? bus.bin_i : hold_q;
      cnt_q <= cnt_d;
      walk_q <= walk_d;
      phase_q <= phase_q ^ tick;
      bus.led_o <= led_d;
      bus.busy_o <= state_d == LAMP_TEST;
    end
  end
endmodule

// File: tb/tb_led_bin_display_ctrl.sv
// tb_led_bin_display_ctrl: directed scoreboard bench for led_bin_display_ctrl
// (WIDTH=4, TICK_DIV=4).
module tb_led_bin_display_ctrl;
  localparam int W = 4;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [4:0] sb[$];
  bit m_state;
  logic [3:0] m_hold;
  int m_cnt, m_walk;
  bit m_phase;
  led_bin_display_ctrl_if #(.WIDTH(W)) bus ();
  led_bin_display_ctrl #(.WIDTH(W), .TICK_DIV(T)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Reference behaviour: push the expected {led,busy} for this edge, then compare after it.
  task automatic step();
    logic [3:0] mapped, gb;
    logic [4:0] exp_v, got;
    bit tk;
    if (rst) begin
      m_state = 0; m_hold = '0; m_cnt = 0; m_walk = 0; m_phase = 0;
      exp_v = '0;
    end else begin
      gb[3] = m_hold[3];
      for (int i = 2; i >= 0; i--) gb[i] = m_hold[i] ^ gb[i+1];
      mapped = bus.mode_i == 2'b00 ? m_hold :
               bus.mode_i == 2'b01 ? gb :
               (bus.mode_i == 2'b10 && !m_phase) ? m_hold : 4'b0000;
      tk = m_cnt == T - 1;
      m_phase = m_phase ^ tk;
      m_cnt = tk ? 0 : m_cnt + 1;
      if (!m_state && bus.test_i) begin
        m_state = 1; m_cnt = 0; m_walk = 0;
      end else if (m_state && tk) begin
        if (m_walk == W - 1) m_state = 0;
        else m_walk++;
      end
      if (bus.load_i) m_hold = bus.bin_i;
      exp_v = {m_state ? 4'(1 << m_walk) : mapped, m_state};
    end
    sb.push_back(exp_v);
    @(posedge clk);
    #1;
    got = {bus.led_o, bus.busy_o};
    exp_v = sb.pop_front();
    chk("model", 32'(got), 32'(exp_v));
  endtask
  initial begin
    int ones, busy_cnt;
    bus.bin_i = '0; bus.load_i = 0; bus.mode_i = 2'b00; bus.test_i = 0;
    rst = 1;
    step(); step();
    chk("rst_led", 32'(bus.led_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    rst = 0;
    bus.mode_i = 2'b00; bus.bin_i = 4'b1011; bus.load_i = 1;
    step();
    bus.load_i = 0; bus.bin_i = 4'b0000;
    step();
    chk("bin_load", 32'(bus.led_o), 32'b1011);
    repeat (3) step();
    chk("bin_hold", 32'(bus.led_o), 32'b1011);
    bus.mode_i = 2'b01; bus.bin_i = 4'b1110; bus.load_i = 1;
    step();
    bus.load_i = 0;
    step();
    chk("gray", 32'(bus.led_o), 32'b1011);
    bus.mode_i = 2'b10; bus.bin_i = 4'b1111; bus.load_i = 1;
    step();
    bus.load_i = 0;
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (bus.led_o == 4'b1111) ones++;
    end
    chk("blink_on_cycles", 32'(ones), 8);
    bus.mode_i = 2'b11;
    step();
    chk("blank", 32'(bus.led_o), 0);
    bus.mode_i = 2'b00; bus.bin_i = 4'b0101; bus.load_i = 1;
    step();
    bus.load_i = 0;
    step();
    chk("pre_test", 32'(bus.led_o), 32'b0101);
    bus.test_i = 1;
    step();
    bus.test_i = 0;
    chk("walk_start", 32'({bus.led_o, bus.busy_o}), 32'b00011);
    busy_cnt = 1;
    for (int i = 1; i < 20; i++) begin
      bus.load_i = i == 6; bus.test_i = i == 6; bus.bin_i = 4'b0011;
      step();
      if (bus.busy_o) busy_cnt++;
      if (i < 16) chk("walk", 32'(bus.led_o), 32'(1 << (i / 4)));
    end
    bus.load_i = 0; bus.test_i = 0;
    chk("busy_len", 32'(busy_cnt), 16);
    chk("post_test", 32'({bus.led_o, bus.busy_o}), 32'b00110);
    bus.test_i = 1;
    step();
    bus.test_i = 0;
    repeat (8) step();
    chk("mid_walk", 32'(bus.led_o), 32'b0100);
    rst = 1;
    step();
    chk("rst_mid", 32'({bus.led_o, bus.busy_o}), 0);
    rst = 0;
    repeat (3) step();
    chk("rst_show", 32'({bus.led_o, bus.busy_o}), 0);
    bus.bin_i = 4'b1001; bus.load_i = 1; bus.test_i = 1;
    step();
    bus.load_i = 0; bus.test_i = 0;
    chk("load_and_test", 32'({bus.led_o, bus.busy_o}), 32'b00011);
    repeat (16) step();
    chk("load_and_test_end", 32'({bus.led_o, bus.busy_o}), 32'b10010);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_bin_display_ctrl.md
LED_BIN_DISPLAY_CTRL -- requirements
Module: led_bin_display_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, sets the LED/value bit count; legal range 2..16.
REQ-002 Parameter TICK_DIV, default 25_000_000, sets the clk cycles per display tick; legal value >= 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 bin_i  input  WIDTH  value to display.
REQ-006 load_i  input  1  when high at a clk edge, bin_i SHALL be captured.
REQ-007 mode_i  input  2  display mode: 00 binary, 01 Gray-decoded, 10 blink, 11 blank.
REQ-008 test_i  input  1  lamp-test request, sampled each edge.
REQ-009 led_o  output  WIDTH  registered LED drive; bit i drives LED of weight 2^i.
REQ-010 busy_o  output  1  registered; high while the lamp test runs.

Function
REQ-011 Hold register hold_q SHALL load bin_i on every edge with load_i=1, in any state; otherwise it SHALL keep its value.
REQ-012 led_o SHALL be registered from hold_q, the current mode_i and FSM state: load at edge k -> new value on led_o after edge k+1 (2-edge latency); a mode_i change SHALL take effect after 1 edge.
REQ-013 Mode 00: led_o = hold_q.
REQ-014 Mode 01: led_o = Gray-to-binary of hold_q; MSB passes through, bit i = hold_q[i] XOR decoded bit i+1.
REQ-015 Mode 10: led_o = hold_q while blink_phase=0, all zeros while blink_phase=1.
REQ-016 Mode 11: led_o = all zeros.
REQ-017 Tick counter SHALL count 0..TICK_DIV-1, wrap to 0, and assert an internal tick for the one cycle at TICK_DIV-1.
REQ-018 blink_phase SHALL toggle on each tick, in all modes and states.
REQ-019 FSM states: SHOW and LAMP_TEST.
REQ-020 SHOW -> LAMP_TEST on an edge with test_i=1, which also clears the tick counter and the walk index.
REQ-021 In LAMP_TEST, led_o SHALL be a one-hot walk starting at bit 0 and advancing one bit per tick; each step lasts exactly TICK_DIV cycles.
REQ-022 In LAMP_TEST, after bit WIDTH-1 has been shown for one tick, the FSM SHALL return to SHOW.
REQ-023 On return to SHOW, led_o SHALL resume the mode-mapped hold_q on the following edge.
REQ-024 In LAMP_TEST, test_i SHALL be ignored; the test SHALL not restart.
REQ-025 busy_o SHALL be 1 for exactly WIDTH*TICK_DIV cycles per lamp test.
REQ-026 When load_i and test_i are both high on the same edge, both SHALL take effect.

Reset
REQ-027 On rst=1 at an edge: state=SHOW, hold_q=0, led_o=0, busy_o=0, tick counter=0, blink_phase=0, walk index=0.
REQ-028 rst SHALL override all other inputs, including a lamp test in progress.

Structure
REQ-029 Package led_display_pkg SHALL hold the mode enum typedef (MODE_BIN, MODE_GRAY, MODE_BLINK, MODE_BLANK) and the FSM state enum.
REQ-030 Gray decode SHALL be a parametrised combinational sub-module gray_to_bin (parameter WIDTH).
REQ-031 Tick counter width SHALL be $clog2(TICK_DIV).

Verification (WIDTH=4, TICK_DIV=4)
REQ-032 Reset: rst=1 for 2 edges -> led_o=0000, busy_o=0.
REQ-033 Binary mode: mode_i=00, bin_i=1011, load_i pulsed at edge k -> led_o=1011 after edge k+1, unchanged until the next load.
REQ-034 Gray mode: mode_i=01, load bin_i=1110 -> led_o=1011.
REQ-035 Blink mode: mode_i=10, hold_q=1111 -> led_o alternates 1111/0000 every 4 cycles; mode_i=11 -> led_o=0000 one edge later.
REQ-036 Lamp test: mode_i=00, hold_q=0101, test_i pulsed -> led_o shows 0001, 0010, 0100, 1000 for 4 cycles each and busy_o=1 for 16 cycles. A load of 0011 during the test is retained, so led_o=0011 after the test, and a second test_i during the test is ignored.
REQ-037 Reset mid-test: rst=1 during step 0100 -> next edge led_o=0000, busy_o=0, state SHOW.
